// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    // Instruction encodings the fetch stage knows about
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    // Sequential PC step (one 32-bit word)
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Next sequential fetch address; wraps naturally at 2^32
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Control/data bundle between the fetch stage and its neighbours
// (decode, hazard unit, debug unit, program loader).
interface if_stage_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic               i_start;
    logic               i_imem_we;
    logic [NB_ADDR-1:0] i_imem_addr;
    logic [NB_DATA-1:0] i_imem_data;
    logic               i_jump;
    logic [NB_DATA-1:0] i_addr2jump;
    logic               i_stop;
    logic               i_stall;
    logic               i_debug_mode;
    logic               i_step;
    logic [NB_DATA-1:0] o_instruction;
    logic [NB_DATA-1:0] o_pc;
    logic               o_running;
    logic               o_halted;
    logic [NB_DATA-1:0] o_fetch_count;

    // Surrounding pipeline / debug logic drives the controls
    modport master (
        output i_start, i_imem_we, i_imem_addr, i_imem_data,
               i_jump, i_addr2jump, i_stop, i_stall, i_debug_mode, i_step,
        input  o_instruction, o_pc, o_running, o_halted, o_fetch_count
    );

    // The fetch stage itself
    modport slave (
        input  i_start, i_imem_we, i_imem_addr, i_imem_data,
               i_jump, i_addr2jump, i_stop, i_stall, i_debug_mode, i_step,
        output o_instruction, o_pc, o_running, o_halted, o_fetch_count
    );
endinterface

// File: rtl/if_stage_instr_mem.sv
// Instruction memory: one synchronous write port for program load and
// one asynchronous read port for fetch. Contents are never reset.
module instr_mem #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0] rdata
);
    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    // Program-load write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction memory and IF/ID register.
// Control FSM: IDLE (program load) -> RUN -> HALTED, restart via i_start.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic        clk,
    input  logic        i_reset,
    if_stage_if.slave   bus
);
    state_t             state_q;
    state_t             state_d;

    logic [NB_DATA-1:0] pc_p0;
    logic [NB_DATA-1:0] ifid_instr_p1;
    logic [NB_DATA-1:0] ifid_pc_p1;
    logic [NB_DATA-1:0] fetch_cnt;

    logic [NB_DATA-1:0] imem_rdata;
    logic               imem_we;
    logic               adv_en;
    logic               do_init;
    logic               do_halt;
    logic               do_fetch;

    // Word address drops the byte offset; upper PC bits alias (wrap) into memory
    instr_mem #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_instr_mem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (bus.i_imem_addr),
        .wdata (bus.i_imem_data),
        .raddr (pc_p0[NB_ADDR+1:2]),
        .rdata (imem_rdata)
    );

    // Stall wins over everything except stop; in debug mode only a step advances
    assign adv_en = !bus.i_stall && (!bus.i_debug_mode || bus.i_step);

    // State register
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle datapath controls
    always_comb begin
        state_d  = state_q;
        do_init  = 1'b0;
        do_halt  = 1'b0;
        do_fetch = 1'b0;
        imem_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                imem_we = bus.i_imem_we;
                if (bus.i_start) begin
                    state_d = ST_RUN;
                    do_init = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.i_stop) begin
                    state_d = ST_HALTED;
                    do_halt = 1'b1;
                end else begin
                    do_fetch = adv_en;
                end
            end
            ST_HALTED: begin
                if (bus.i_start) begin
                    state_d = ST_RUN;
                    do_init = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PC, IF/ID register and fetch counter; the jump target replaces PC+4
    // only on an advancing edge, so the word fetched alongside it is the delay slot
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_p0         <= '0;
            ifid_instr_p1 <= NB_DATA'(NOP);
            ifid_pc_p1    <= '0;
            fetch_cnt     <= '0;
        end else if (do_init) begin
            pc_p0         <= '0;
            ifid_instr_p1 <= NB_DATA'(NOP);
            ifid_pc_p1    <= '0;
            fetch_cnt     <= '0;
        end else if (do_halt) begin
            ifid_instr_p1 <= NB_DATA'(NOP);
        end else if (do_fetch) begin
            ifid_instr_p1 <= imem_rdata;
            ifid_pc_p1    <= pc_p0;
            pc_p0         <= bus.i_jump ? bus.i_addr2jump : NB_DATA'(next_seq_pc(32'(pc_p0)));
            fetch_cnt     <= fetch_cnt + 1'b1;
        end
    end

    assign bus.o_instruction = ifid_instr_p1;
    assign bus.o_pc          = ifid_pc_p1;
    assign bus.o_running     = (state_q == ST_RUN);
    assign bus.o_halted      = (state_q == ST_HALTED);
    assign bus.o_fetch_count = fetch_cnt;

endmodule
